// File: rtl/sdc_dma_wb2axi_if.sv
// Bus bundles for the SD DMA bridge: classic Wishbone and single-beat AXI4.

// Classic Wishbone DMA port; master is the SD controller, slave is the bridge.
interface sdc_dma_wb_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// AXI4 port; master is the bridge, slave is the interconnect DMA port.
interface sdc_dma_axi_if #(
  parameter int unsigned AXI_ID_WIDTH = 4
);
  logic [AXI_ID_WIDTH-1:0] aw_id;
  logic [31:0]             aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_valid;
  logic                    aw_ready;

  logic [31:0]             w_data;
  logic [3:0]              w_strb;
  logic                    w_last;
  logic                    w_valid;
  logic                    w_ready;

  logic [AXI_ID_WIDTH-1:0] b_id;
  logic [1:0]              b_resp;
  logic                    b_valid;
  logic                    b_ready;

  logic [AXI_ID_WIDTH-1:0] ar_id;
  logic [31:0]             ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_valid;
  logic                    ar_ready;

  logic [AXI_ID_WIDTH-1:0] r_id;
  logic [31:0]             r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/sdc_dma_wb2axi.sv
// Single-outstanding bridge: one classic Wishbone cycle -> one single-beat AXI4
// transaction. Abandoned Wishbone cycles still let AXI finish, silently.
module sdc_dma_wb2axi #(
  parameter int unsigned AXI_ID_WIDTH = 4,
  parameter int unsigned AXI_ID       = 1
) (
  input  logic          aclk,
  input  logic          aresetn,
  sdc_dma_wb_if.slave   wb,
  sdc_dma_axi_if.master axi
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic [7:0] AXI_LEN   = 8'd0;
  localparam logic [2:0] AXI_SIZE  = 3'b010;
  localparam logic [1:0] AXI_BURST = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_RESP,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [STRB_W-1:0]   r_sel;
  logic                r_aw_valid;
  logic                r_w_valid;
  logic                r_aw_done;
  logic                r_w_done;
  logic                r_b_ready;
  logic                r_ar_valid;
  logic                r_r_ready;
  logic                r_ack;
  logic                r_err;
  logic                r_abandon;

  logic                w_req;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_abandon;
  logic                w_in_axi;
  logic                w_unused;

  assign w_req     = wb.wb_cyc_i & wb.wb_stb_i;
  assign w_aw_hs   = r_aw_valid & axi.aw_ready;
  assign w_w_hs    = r_w_valid & axi.w_ready;
  // A cycle dropping on the same edge as the response also counts as abandoned.
  assign w_abandon = r_abandon | ~wb.wb_cyc_i;
  assign w_in_axi  = (r_state != S_IDLE) && (r_state != S_DONE);

  // Bridge FSM: latch request, run the AXI transaction, report once on Wishbone.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_sel      <= '0;
      r_aw_valid <= 1'b0;
      r_w_valid  <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_b_ready  <= 1'b0;
      r_ar_valid <= 1'b0;
      r_r_ready  <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_abandon  <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      if (w_in_axi && !wb.wb_cyc_i) begin
        r_abandon <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_abandon <= 1'b0;
          if (w_req) begin
            r_addr  <= {wb.wb_adr_i[ADDR_W-1:2], 2'b00};
            r_sel   <= wb.wb_sel_i;
            r_wdata <= wb.wb_dat_i;
            if (wb.wb_we_i) begin
              r_aw_valid <= 1'b1;
              r_w_valid  <= 1'b1;
              r_aw_done  <= 1'b0;
              r_w_done   <= 1'b0;
              r_state    <= S_WR_REQ;
            end else begin
              r_ar_valid <= 1'b1;
              r_state    <= S_RD_REQ;
            end
          end
        end

        S_WR_REQ: begin
          if (w_aw_hs) begin
            r_aw_valid <= 1'b0;
            r_aw_done  <= 1'b1;
          end
          if (w_w_hs) begin
            r_w_valid <= 1'b0;
            r_w_done  <= 1'b1;
          end
          if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
            r_b_ready <= 1'b1;
            r_state   <= S_WR_RESP;
          end
        end

        S_WR_RESP: begin
          if (axi.b_valid) begin
            r_b_ready <= 1'b0;
            if (w_abandon) begin
              r_abandon <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_ack   <= ~axi.b_resp[1];
              r_err   <= axi.b_resp[1];
              r_state <= S_DONE;
            end
          end
        end

        S_RD_REQ: begin
          if (axi.ar_ready) begin
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b1;
            r_state    <= S_RD_RESP;
          end
        end

        S_RD_RESP: begin
          if (axi.r_valid) begin
            r_r_ready <= 1'b0;
            r_rdata   <= axi.r_data;
            if (w_abandon) begin
              r_abandon <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_ack   <= ~axi.r_resp[1];
              r_err   <= axi.r_resp[1];
              r_state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          r_abandon <= 1'b0;
          r_state   <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Wishbone side outputs.
  assign wb.wb_dat_o = r_rdata;
  assign wb.wb_ack_o = r_ack;
  assign wb.wb_err_o = r_err;

  // AXI write address/data/response channels.
  assign axi.aw_id    = AXI_ID_WIDTH'(AXI_ID);
  assign axi.aw_addr  = r_addr;
  assign axi.aw_len   = AXI_LEN;
  assign axi.aw_size  = AXI_SIZE;
  assign axi.aw_burst = AXI_BURST;
  assign axi.aw_valid = r_aw_valid;
  assign axi.w_data   = r_wdata;
  assign axi.w_strb   = r_sel;
  assign axi.w_last   = 1'b1;
  assign axi.w_valid  = r_w_valid;
  assign axi.b_ready  = r_b_ready;

  // AXI read address/data channels.
  assign axi.ar_id    = AXI_ID_WIDTH'(AXI_ID);
  assign axi.ar_addr  = r_addr;
  assign axi.ar_len   = AXI_LEN;
  assign axi.ar_size  = AXI_SIZE;
  assign axi.ar_burst = AXI_BURST;
  assign axi.ar_valid = r_ar_valid;
  assign axi.r_ready  = r_r_ready;

  // IDs, r_last and the low resp/address bits carry no information here.
  assign w_unused = ^{axi.b_id, axi.r_id, axi.r_last, axi.b_resp[0],
                      axi.r_resp[0], wb.wb_adr_i[1:0]};

endmodule
